aes_challenge_ctrl: RTL and testbench

//  Byte-stream front/back end for the AES-128 encryption core in the challenge-response path.

---
 rtl/aes_pkg.sv | 14 +
 rtl/aes_challenge_ctrl.sv | 122 ++++++++++++
 tb/tb_aes_challenge_ctrl.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES block geometry and controller state encoding.
package aes_pkg;

  localparam int unsigned AES_BLOCK_BITS  = 128;
  localparam int unsigned AES_BLOCK_BYTES = 16;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_START   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_SEND    = 2'd3
  } state_e;

endpackage

// File: rtl/aes_challenge_ctrl.sv
// Byte-stream wrapper around an AES-128 core: gathers a 16-byte challenge, runs the
// core with timeout/retry and streams the 16-byte ciphertext back out.
module aes_challenge_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 32,
  parameter int unsigned MAX_RETRY      = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [7:0]   out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] aes_plaintext,
  output logic         aes_start,
  input  logic         aes_done,
  input  logic [127:0] aes_ciphertext,
  input  logic         abort,
  output logic         busy,
  output logic         err_timeout
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_e                    state_q;
  logic [3:0]                byte_cnt_q;
  logic [TW-1:0]             timer_q;
  logic [RW-1:0]             retry_q;
  logic [AES_BLOCK_BITS-1:0] pt_q;
  logic [AES_BLOCK_BITS-1:0] shreg_q;
  logic                      aes_start_q;
  logic                      out_valid_q;

  logic wait_expired;
  logic retry_left;

  // A WAIT cycle with the timer exhausted and no completion from the core
  assign wait_expired = (state_q == ST_WAIT) && !aes_done && (timer_q == '0);
  assign retry_left   = (retry_q < RW'(MAX_RETRY));

  assign in_ready      = !rst && (state_q == ST_COLLECT);
  assign busy          = (state_q != ST_COLLECT);
  assign out_data      = shreg_q[AES_BLOCK_BITS-1 -: 8];
  assign out_valid     = out_valid_q;
  assign aes_start     = aes_start_q;
  assign aes_plaintext = pt_q;
  // Flagged in the final expired WAIT cycle so it lands exactly TIMEOUT_CYCLES after the last start
  assign err_timeout   = !rst && !abort && wait_expired && !retry_left;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_COLLECT;
      byte_cnt_q  <= '0;
      timer_q     <= '0;
      retry_q     <= '0;
      pt_q        <= '0;
      shreg_q     <= '0;
      aes_start_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (abort) begin
      state_q     <= ST_COLLECT;
      byte_cnt_q  <= '0;
      timer_q     <= '0;
      retry_q     <= '0;
      aes_start_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      aes_start_q <= 1'b0;
      unique case (state_q)
        ST_COLLECT: begin
          if (in_valid && in_ready) begin
            pt_q       <= {pt_q[AES_BLOCK_BITS-9:0], in_data};
            byte_cnt_q <= byte_cnt_q + 4'd1;
            if (byte_cnt_q == 4'(AES_BLOCK_BYTES - 1)) begin
              state_q     <= ST_START;
              aes_start_q <= 1'b1;
            end
          end
        end
        ST_START: begin
          timer_q <= TW'(TIMEOUT_CYCLES - 1);
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (aes_done) begin
            shreg_q     <= aes_ciphertext;
            retry_q     <= '0;
            state_q     <= ST_SEND;
            out_valid_q <= 1'b1;
          end else if (timer_q == '0) begin
            if (retry_left) begin
              retry_q     <= retry_q + RW'(1);
              state_q     <= ST_START;
              aes_start_q <= 1'b1;
            end else begin
              retry_q <= '0;
              state_q <= ST_COLLECT;
            end
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        ST_SEND: begin
          if (out_valid_q && out_ready) begin
            shreg_q    <= {shreg_q[AES_BLOCK_BITS-9:0], 8'h00};
            byte_cnt_q <= byte_cnt_q + 4'd1;
            if (byte_cnt_q == 4'(AES_BLOCK_BYTES - 1)) begin
              state_q     <= ST_COLLECT;
              out_valid_q <= 1'b0;
            end
          end
        end
        default: state_q <= ST_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_challenge_ctrl.sv
// Self-checking bench for aes_challenge_ctrl with a behavioural AES-core responder.
module tb_aes_challenge_ctrl;

  localparam int unsigned TO = 32;
  localparam int unsigned MR = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   in_data = 8'h00;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] aes_plaintext;
  logic         aes_start;
  logic         aes_done = 1'b0;
  logic [127:0] aes_ciphertext = '0;
  logic         abort = 1'b0;
  logic         busy;
  logic         err_timeout;

  aes_challenge_ctrl #(.TIMEOUT_CYCLES(TO), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .aes_plaintext(aes_plaintext), .aes_start(aes_start),
    .aes_done(aes_done), .aes_ciphertext(aes_ciphertext),
    .abort(abort), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Core responder configuration and observation logs
  logic [127:0] core_ct = '0;
  int           core_delay = 1;
  int           core_ignore = 0;
  bit           core_answer = 1'b1;
  int           core_nstarts = 0;
  int           done_cnt = 0;
  int           start_log[$];
  int           err_log[$];
  int           ov_log[$];
  logic [7:0]   out_bytes[$];
  int           stall_viol = 0;
  int           both_high = 0;
  logic [7:0]   cur_pt[16];
  int           last_acc = 0;

  // Core model: answers a start after core_delay cycles, optionally ignoring the first starts
  initial begin
    forever begin
      @(posedge clk); #1;
      aes_done = 1'b0;
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) begin
          aes_done       = 1'b1;
          aes_ciphertext = core_ct;
        end
      end
      if (aes_start) begin
        start_log.push_back(cyc);
        core_nstarts++;
        if (core_answer && core_nstarts > core_ignore) done_cnt = core_delay;
      end
    end
  end

  // Output-side monitor: transfers, stall stability, pulse logging
  initial begin
    bit         prev_stall;
    bit         prev_valid;
    logic [7:0] prev_data;
    prev_stall = 0; prev_valid = 0; prev_data = '0;
    forever begin
      @(negedge clk);
      if (aes_start && err_timeout) both_high++;
      if (err_timeout) err_log.push_back(cyc);
      if (rst) begin
        prev_stall = 0; prev_valid = 0;
      end else begin
        if (prev_stall && (!out_valid || out_data !== prev_data)) stall_viol++;
        if (out_valid && !prev_valid) ov_log.push_back(cyc);
        if (out_valid && out_ready) out_bytes.push_back(out_data);
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_valid = out_valid;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic clear_logs();
    sample();
    start_log.delete(); err_log.delete(); ov_log.delete(); out_bytes.delete();
    stall_viol = 0; both_high = 0; core_nstarts = 0; done_cnt = 0;
    core_ignore = 0; core_answer = 1'b1;
  endtask

  function automatic logic [127:0] pack_pt();
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r = {r[119:0], cur_pt[i]};
    return r;
  endfunction

  task automatic randomize_txn();
    for (int i = 0; i < 16; i++) cur_pt[i] = 8'($urandom());
    core_ct = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic send_bytes(input int n, input int gap_pct);
    for (int i = 0; i < n; i++) begin
      step();
      while ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        step();
      end
      in_valid = 1'b1;
      in_data  = cur_pt[i];
      sample();
      vectors++;
      if (in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL in_ready_collect: got %b want 1 (byte %0d)", in_ready, i);
      end
      last_acc = cyc;
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic collect_out(input int pct);
    int budget;
    budget = 0;
    while (out_bytes.size() < 16 && budget < 3000) begin
      step();
      out_ready = ($urandom_range(99) < pct);
      sample();
      budget++;
    end
    step();
    out_ready = 1'b0;
    vectors++;
    if (out_bytes.size() < 16) begin
      miscompares++;
      $display("FAIL out_stream_timeout: got %0d bytes want 16", out_bytes.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    sample();
    vectors += 6;
    if (in_ready !== 1'b0)  begin miscompares++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    if (aes_start !== 1'b0) begin miscompares++; $display("FAIL rst_aes_start: got %b want 0", aes_start); end
    if (err_timeout !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %b want 0", err_timeout); end
    if (busy !== 1'b0)      begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (aes_plaintext !== 128'h0) begin miscompares++; $display("FAIL rst_plaintext: got %h want 0", aes_plaintext); end
    step();
    rst = 1'b0;
    sample();
    vectors += 2;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL post_rst_in_ready: got %b want 1", in_ready); end
    if (busy !== 1'b0)     begin miscompares++; $display("FAIL post_rst_busy: got %b want 0", busy); end
  endtask

  task automatic test_known_vector();
    int s;
    clear_logs();
    core_ct    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    core_delay = 11;
    for (int i = 0; i < 16; i++) cur_pt[i] = 8'(i * 17);
    send_bytes(16, 0);
    collect_out(100);
    s = (start_log.size() > 0) ? start_log[0] : -1;
    vectors += 5;
    if (aes_plaintext !== 128'h00112233445566778899aabbccddeeff) begin
      miscompares++; $display("FAIL kv_plaintext: got %h want 00112233445566778899aabbccddeeff", aes_plaintext);
    end
    if (start_log.size() != 1) begin miscompares++; $display("FAIL kv_start_count: got %0d want 1", start_log.size()); end
    if (s != last_acc + 1) begin miscompares++; $display("FAIL kv_start_cycle: got %0d want %0d", s, last_acc + 1); end
    if (ov_log.size() == 0 || ov_log[0] != s + 12) begin
      miscompares++; $display("FAIL kv_out_valid_cycle: got %0d want %0d", (ov_log.size() > 0) ? ov_log[0] : -1, s + 12);
    end
    if (err_log.size() != 0) begin miscompares++; $display("FAIL kv_err: got %0d pulses want 0", err_log.size()); end
    for (int i = 0; i < 16; i++) begin
      logic [7:0] e;
      logic [7:0] g;
      e = core_ct[127-8*i -: 8];
      g = (i < out_bytes.size()) ? out_bytes[i] : 8'hxx;
      vectors++;
      if (g !== e) begin miscompares++; $display("FAIL kv_byte%0d: got %h want %h", i, g, e); end
    end
    sample();
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL kv_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    for (int it = 0; it < 3; it++) begin
      clear_logs();
      randomize_txn();
      core_delay = $urandom_range(1, 20);
      send_bytes(16, 30);
      collect_out(50);
      vectors += 4;
      if (aes_plaintext !== pack_pt()) begin miscompares++; $display("FAIL bp_plaintext: got %h want %h", aes_plaintext, pack_pt()); end
      if (start_log.size() != 1) begin miscompares++; $display("FAIL bp_start_count: got %0d want 1", start_log.size()); end
      if (out_bytes.size() != 16) begin miscompares++; $display("FAIL bp_byte_count: got %0d want 16", out_bytes.size()); end
      if (stall_viol != 0) begin miscompares++; $display("FAIL bp_stall_stable: got %0d violations want 0", stall_viol); end
      for (int i = 0; i < 16; i++) begin
        logic [7:0] e;
        logic [7:0] g;
        e = core_ct[127-8*i -: 8];
        g = (i < out_bytes.size()) ? out_bytes[i] : 8'hxx;
        vectors++;
        if (g !== e) begin miscompares++; $display("FAIL bp_byte%0d: got %h want %h", i, g, e); end
      end
    end
  endtask

  task automatic test_retry();
    int s0, s1;
    clear_logs();
    randomize_txn();
    core_ignore = 1;
    core_delay  = 7;
    send_bytes(16, 0);
    collect_out(100);
    s0 = (start_log.size() > 0) ? start_log[0] : -1;
    s1 = (start_log.size() > 1) ? start_log[1] : -1;
    vectors += 5;
    if (start_log.size() != 2) begin miscompares++; $display("FAIL rt_start_count: got %0d want 2", start_log.size()); end
    if (s1 - s0 != TO + 1) begin miscompares++; $display("FAIL rt_start_gap: got %0d want %0d", s1 - s0, TO + 1); end
    if (ov_log.size() == 0 || ov_log[0] != s1 + 8) begin
      miscompares++; $display("FAIL rt_out_valid_cycle: got %0d want %0d", (ov_log.size() > 0) ? ov_log[0] : -1, s1 + 8);
    end
    if (err_log.size() != 0) begin miscompares++; $display("FAIL rt_err: got %0d pulses want 0", err_log.size()); end
    if (aes_plaintext !== pack_pt()) begin miscompares++; $display("FAIL rt_plaintext: got %h want %h", aes_plaintext, pack_pt()); end
    for (int i = 0; i < 16; i++) begin
      logic [7:0] e;
      logic [7:0] g;
      e = core_ct[127-8*i -: 8];
      g = (i < out_bytes.size()) ? out_bytes[i] : 8'hxx;
      vectors++;
      if (g !== e) begin miscompares++; $display("FAIL rt_byte%0d: got %h want %h", i, g, e); end
    end
  endtask

  task automatic test_timeout();
    int b, last_s;
    clear_logs();
    randomize_txn();
    core_answer = 1'b0;
    send_bytes(16, 0);
    b = 0;
    while (err_log.size() == 0 && b < 400) begin
      sample();
      b++;
    end
    sample();
    vectors += 5;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL to_in_ready: got %b want 1", in_ready); end
    if (busy !== 1'b0)     begin miscompares++; $display("FAIL to_busy: got %b want 0", busy); end
    if (start_log.size() != MR + 1) begin miscompares++; $display("FAIL to_start_count: got %0d want %0d", start_log.size(), MR + 1); end
    if (err_log.size() != 1) begin miscompares++; $display("FAIL to_err_count: got %0d want 1", err_log.size()); end
    if (both_high != 0) begin miscompares++; $display("FAIL to_start_err_overlap: got %0d want 0", both_high); end
    for (int k = 1; k < start_log.size(); k++) begin
      vectors++;
      if (start_log[k] - start_log[k-1] != TO + 1) begin
        miscompares++; $display("FAIL to_start_gap%0d: got %0d want %0d", k, start_log[k] - start_log[k-1], TO + 1);
      end
    end
    last_s = (start_log.size() > 0) ? start_log[start_log.size()-1] : -1;
    vectors++;
    if (err_log.size() == 0 || err_log[0] - last_s != TO) begin
      miscompares++; $display("FAIL to_err_delay: got %0d want %0d", (err_log.size() > 0) ? err_log[0] - last_s : -1, TO);
    end
    repeat (5) sample();
    vectors++;
    if (start_log.size() != MR + 1) begin miscompares++; $display("FAIL to_no_more_starts: got %0d want %0d", start_log.size(), MR + 1); end
  endtask

  task automatic test_abort();
    int b;
    clear_logs();
    randomize_txn();
    core_delay = 9;
    send_bytes(7, 0);
    step(); abort = 1'b1;
    step(); abort = 1'b0;
    randomize_txn();
    send_bytes(16, 20);
    vectors += 3;
    if (start_log.size() != 1) begin miscompares++; $display("FAIL ab_start_count: got %0d want 1", start_log.size()); end
    if (start_log.size() == 0 || start_log[0] != last_acc + 1) begin
      miscompares++; $display("FAIL ab_start_cycle: got %0d want %0d", (start_log.size() > 0) ? start_log[0] : -1, last_acc + 1);
    end
    if (aes_plaintext !== pack_pt()) begin miscompares++; $display("FAIL ab_plaintext: got %h want %h", aes_plaintext, pack_pt()); end
    collect_out(100);
    for (int i = 0; i < 16; i++) begin
      logic [7:0] e;
      logic [7:0] g;
      e = core_ct[127-8*i -: 8];
      g = (i < out_bytes.size()) ? out_bytes[i] : 8'hxx;
      vectors++;
      if (g !== e) begin miscompares++; $display("FAIL ab_byte%0d: got %h want %h", i, g, e); end
    end

    // Abort during WAIT: a late done must then be ignored
    clear_logs();
    randomize_txn();
    core_delay = 20;
    send_bytes(16, 0);
    b = 0;
    while (start_log.size() == 0 && b < 50) begin sample(); b++; end
    repeat (3) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    sample();
    vectors += 2;
    if (busy !== 1'b0)  begin miscompares++; $display("FAIL abw_busy: got %b want 0", busy); end
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL abw_in_ready: got %b want 1", in_ready); end
    repeat (30) sample();
    vectors += 4;
    if (ov_log.size() != 0)  begin miscompares++; $display("FAIL abw_out_valid: got %0d rises want 0", ov_log.size()); end
    if (err_log.size() != 0) begin miscompares++; $display("FAIL abw_err: got %0d pulses want 0", err_log.size()); end
    if (start_log.size() != 1) begin miscompares++; $display("FAIL abw_starts: got %0d want 1", start_log.size()); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL abw_busy_late: got %b want 0", busy); end
  endtask

  task automatic test_done_at_timeout();
    int s;
    clear_logs();
    randomize_txn();
    core_delay = TO;
    send_bytes(16, 0);
    collect_out(100);
    s = (start_log.size() > 0) ? start_log[0] : -1;
    vectors += 3;
    if (start_log.size() != 1) begin miscompares++; $display("FAIL dt_start_count: got %0d want 1", start_log.size()); end
    if (err_log.size() != 0) begin miscompares++; $display("FAIL dt_err: got %0d pulses want 0", err_log.size()); end
    if (ov_log.size() == 0 || ov_log[0] != s + TO + 1) begin
      miscompares++; $display("FAIL dt_out_valid_cycle: got %0d want %0d", (ov_log.size() > 0) ? ov_log[0] : -1, s + TO + 1);
    end
    for (int i = 0; i < 16; i++) begin
      logic [7:0] e;
      logic [7:0] g;
      e = core_ct[127-8*i -: 8];
      g = (i < out_bytes.size()) ? out_bytes[i] : 8'hxx;
      vectors++;
      if (g !== e) begin miscompares++; $display("FAIL dt_byte%0d: got %h want %h", i, g, e); end
    end
  endtask

  task automatic test_reset_mid_send();
    int b;
    clear_logs();
    randomize_txn();
    core_delay = 4;
    out_ready  = 1'b0;
    send_bytes(16, 0);
    b = 0;
    while (ov_log.size() == 0 && b < 100) begin sample(); b++; end
    repeat (2) sample();
    vectors++;
    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL rs_stalled_valid: got %b want 1", out_valid); end
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    sample();
    vectors += 4;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rs_out_valid: got %b want 0", out_valid); end
    if (busy !== 1'b0)      begin miscompares++; $display("FAIL rs_busy: got %b want 0", busy); end
    if (in_ready !== 1'b1)  begin miscompares++; $display("FAIL rs_in_ready: got %b want 1", in_ready); end
    if (aes_plaintext !== 128'h0) begin miscompares++; $display("FAIL rs_plaintext: got %h want 0", aes_plaintext); end

    clear_logs();
    randomize_txn();
    core_delay = $urandom_range(1, 25);
    send_bytes(16, 10);
    collect_out(70);
    vectors += 3;
    if (aes_plaintext !== pack_pt()) begin miscompares++; $display("FAIL rs2_plaintext: got %h want %h", aes_plaintext, pack_pt()); end
    if (start_log.size() != 1) begin miscompares++; $display("FAIL rs2_start_count: got %0d want 1", start_log.size()); end
    if (stall_viol != 0) begin miscompares++; $display("FAIL rs2_stall_stable: got %0d want 0", stall_viol); end
    for (int i = 0; i < 16; i++) begin
      logic [7:0] e;
      logic [7:0] g;
      e = core_ct[127-8*i -: 8];
      g = (i < out_bytes.size()) ? out_bytes[i] : 8'hxx;
      vectors++;
      if (g !== e) begin miscompares++; $display("FAIL rs2_byte%0d: got %h want %h", i, g, e); end
    end
  endtask

  initial begin
    test_reset();
    test_known_vector();
    test_backpressure();
    test_retry();
    test_timeout();
    test_abort();
    test_done_at_timeout();
    test_reset_mid_send();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
